// File: rtl/note_player_if.sv
// Note request/response bundle between the note player and the pattern sequencer.
// The player pulses o_note_stb; the sequencer answers with the note fields and i_note_valid.
interface note_player_if;
  logic       o_note_stb;
  logic       i_note_valid;
  logic [5:0] i_note;
  logic [4:0] i_note_len;
  logic [3:0] i_instrument;

  // Player side: issues the request, receives the note.
  modport master (
    output o_note_stb,
    input  i_note_valid,
    input  i_note,
    input  i_note_len,
    input  i_instrument
  );

  // Sequencer side: sees the request, returns the note.
  modport slave (
    input  o_note_stb,
    output i_note_valid,
    output i_note,
    output i_note_len,
    output i_instrument
  );
endinterface

// File: rtl/note_player.sv
// Note player: owns song tempo, fetches notes from the sequencer, holds each for
// its encoded duration in tempo ticks, and drives gate/phase increment/instrument
// to the envelope and oscillator stage.
module note_player #(
  parameter int TICK_DIV = 200000,
  parameter int TICK_W   = 18
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  note_player_if.master       seq,
  output logic                o_tick,
  output logic                o_gate,
  output logic [15:0]         o_phase_inc,
  output logic [3:0]          o_instrument,
  output logic                o_playing
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_NOTE = 2'd2,
    PLAY      = 2'd3
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [5:0]        remaining;
  logic              tick;

  // Top-octave phase increment for each semitone (C..B).
  function automatic logic [15:0] base_of(input logic [3:0] semi);
    logic [15:0] b;
    case (semi)
      4'd0:    b = 16'd34297;
      4'd1:    b = 16'd36336;
      4'd2:    b = 16'd38497;
      4'd3:    b = 16'd40786;
      4'd4:    b = 16'd43211;
      4'd5:    b = 16'd45781;
      4'd6:    b = 16'd48503;
      4'd7:    b = 16'd51387;
      4'd8:    b = 16'd54443;
      4'd9:    b = 16'd57681;
      4'd10:   b = 16'd61111;
      default: b = 16'd64745;
    endcase
    return b;
  endfunction

  // Note code to phase increment. Octave is found by constant compares so the
  // divide-by-12 stays a single combinational level; lower octaves shift down.
  function automatic logic [15:0] phase_of(input logic [5:0] note);
    logic [5:0] n;
    logic [2:0] oct;
    logic [5:0] semi;
    if (note == 6'd0) return 16'd0;
    n = note - 6'd1;
    if (n < 6'd12)      oct = 3'd0;
    else if (n < 6'd24) oct = 3'd1;
    else if (n < 6'd36) oct = 3'd2;
    else if (n < 6'd48) oct = 3'd3;
    else if (n < 6'd60) oct = 3'd4;
    else                oct = 3'd5;
    semi = n - ({3'b000, oct} * 6'd12);
    return base_of(semi[3:0]) >> (3'd5 - oct);
  endfunction

  // Tick fires on the last count of the divider; gated so a stop kills it at once.
  assign tick   = i_enable && (tick_cnt == TICK_LAST);
  assign o_tick = tick;

  // Free-running tempo divider, held at zero while playback is stopped.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Playback FSM with registered strobe, gate, pitch, instrument and playing flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      seq.o_note_stb <= 1'b0;
      o_gate         <= 1'b0;
      o_phase_inc    <= '0;
      o_instrument   <= '0;
      o_playing      <= 1'b0;
      remaining      <= '0;
    end else if (!i_enable) begin
      // Stopping silences the voice but keeps the instrument selection.
      state          <= IDLE;
      seq.o_note_stb <= 1'b0;
      o_gate         <= 1'b0;
      o_phase_inc    <= '0;
      o_playing      <= 1'b0;
    end else begin
      seq.o_note_stb <= 1'b0;
      case (state)
        IDLE: begin
          state          <= REQUEST;
          seq.o_note_stb <= 1'b1;
        end
        REQUEST: begin
          state <= WAIT_NOTE;
        end
        WAIT_NOTE: begin
          if (seq.i_note_valid) begin
            o_instrument <= seq.i_instrument;
            o_gate       <= (seq.i_note != 6'd0);
            o_phase_inc  <= phase_of(seq.i_note);
            remaining    <= {1'b0, seq.i_note_len} + 6'd1;
            o_playing    <= 1'b1;
            state        <= PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            remaining <= remaining - 6'd1;
            // Release one tick early for articulation; a one-tick note stays legato.
            if (remaining == 6'd2) o_gate <= 1'b0;
            if (remaining == 6'd1) begin
              state          <= REQUEST;
              seq.o_note_stb <= 1'b1;
              o_playing      <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Testbench for note_player with an 8-cycle tempo tick.
module tb_note_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tick;
  logic        gate;
  logic [15:0] phase;
  logic [3:0]  instr;
  logic        playing;

  note_player_if bus ();

  note_player #(.TICK_DIV(8), .TICK_W(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .seq          (bus),
    .o_tick       (tick),
    .o_gate       (gate),
    .o_phase_inc  (phase),
    .o_instrument (instr),
    .o_playing    (playing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int gate;
    int instr;
  } exp_t;

  typedef struct {
    int note;
    int len;
    int instr;
    int phase;
    int gate;
  } vec_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   play_prev = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: each newly latched note must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (playing && !play_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL latch_unexpected: got phase %0d expected no latch", phase);
      end else begin
        e = exp_q.pop_front();
        check("latch_phase", int'(phase), e.phase);
        check("latch_gate", int'(gate), e.gate);
        check("latch_instr", int'(instr), e.instr);
      end
    end
    play_prev = playing;
  end

  // Steps until o_tick is seen; returns the number of cycles taken.
  task automatic count_to_tick(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      n++;
      if (tick) return;
    end
    n = -1;
  endtask

  // Sequencer model: optionally wait for the strobe, answer 4 cycles later.
  task automatic send_note(input bit need_stb, input int note, input int len,
                           input int ins, input int exp_phase, input int exp_gate);
    bit ok;
    exp_t e;
    if (need_stb) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (bus.o_note_stb) begin
          ok = 1'b1;
          break;
        end
        step();
      end
      check("stb_seen", int'(ok), 1);
    end
    step(4);
    bus.i_note       = 6'(note);
    bus.i_note_len   = 5'(len);
    bus.i_instrument = 4'(ins);
    bus.i_note_valid = 1'b1;
    e.phase = exp_phase;
    e.gate  = exp_gate;
    e.instr = ins;
    exp_q.push_back(e);
    step();
    bus.i_note_valid = 1'b0;
  endtask

  // Runs the current note until the next strobe, tracking ticks and gate release.
  task automatic run_note(output int ticks, output int fall, output int end_gate);
    bit g;
    ticks    = 0;
    fall     = 0;
    end_gate = -1;
    for (int i = 0; i < 400; i++) begin
      if (tick) begin
        ticks++;
        g = gate;
        step();
        if (g && !gate) fall = ticks;
      end else begin
        step();
      end
      if (bus.o_note_stb) begin
        end_gate = int'(gate);
        return;
      end
    end
    ticks = -1;
  endtask

  vec_t vecs[9];

  initial begin
    int n, t0, ticks, fall, eg, stb_cnt;
    vecs = '{
      '{1, 2, 5, 1071, 1},
      '{63, 0, 3, 38497, 1},
      '{13, 1, 9, 2143, 1},
      '{0, 0, 12, 0, 0},
      '{1, 0, 2, 1071, 1},
      '{2, 0, 4, 1135, 1},
      '{12, 1, 1, 2023, 1},
      '{25, 0, 8, 4287, 1},
      '{60, 2, 11, 32372, 1}
    };

    rst = 1'b1;
    enable = 1'b0;
    bus.i_note_valid = 1'b0;
    bus.i_note = '0;
    bus.i_note_len = '0;
    bus.i_instrument = '0;
    step(3);
    rst = 1'b0;
    stb_cnt = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.o_note_stb) stb_cnt++;
      if (tick) n++;
    end
    check("rst_stb", int'(bus.o_note_stb), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_gate", int'(gate), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_instr", int'(instr), 0);
    check("rst_playing", int'(playing), 0);
    check("idle_stb_count", stb_cnt, 0);
    check("idle_tick_count", n, 0);

    // Enable: strobe on the first cycle, first tick 7 cycles after enable, then every 8.
    enable = 1'b1;
    step();
    check("en_stb_pulse", int'(bus.o_note_stb), 1);
    step();
    check("en_stb_single", int'(bus.o_note_stb), 0);
    count_to_tick(n);
    check("first_tick_delay", n + 2, 7);
    count_to_tick(n);
    check("tick_period", n, 8);

    // Table-driven notes, each answered to the player's strobe.
    for (int v = 0; v < 9; v++) begin
      send_note(v != 0, vecs[v].note, vecs[v].len, vecs[v].instr, vecs[v].phase, vecs[v].gate);
      run_note(ticks, fall, eg);
      check($sformatf("v%0d_ticks", v), ticks, vecs[v].len + 1);
      check($sformatf("v%0d_gate_fall", v), fall,
            (vecs[v].gate != 0 && vecs[v].len >= 1) ? vecs[v].len : 0);
      check($sformatf("v%0d_end_gate", v), eg, (vecs[v].len == 0) ? vecs[v].gate : 0);
    end

    // Stop during PLAY: voice silenced, instrument kept, divider restarted.
    send_note(1'b1, 25, 5, 6, 4287, 1);
    step(3);
    enable = 1'b0;
    step();
    check("stop_playing", int'(playing), 0);
    check("stop_gate", int'(gate), 0);
    check("stop_phase", int'(phase), 0);
    check("stop_instr", int'(instr), 6);
    check("stop_tick", int'(tick), 0);
    check("stop_stb", int'(bus.o_note_stb), 0);
    step(2);
    enable = 1'b1;
    step();
    check("reen_stb", int'(bus.o_note_stb), 1);
    count_to_tick(n);
    check("reen_tick_delay", n + 1, 7);

    // Valid pulse while playing must not disturb the held note.
    send_note(1'b0, 13, 3, 9, 2143, 1);
    t0 = int'(tick);
    bus.i_note = 6'd63;
    bus.i_instrument = 4'd7;
    bus.i_note_valid = 1'b1;
    step();
    bus.i_note_valid = 1'b0;
    check("ign_phase", int'(phase), 2143);
    check("ign_instr", int'(instr), 9);
    check("ign_playing", int'(playing), 1);
    run_note(ticks, fall, eg);
    check("ign_ticks", ticks + t0, 4);

    // Reset while waiting for a note: everything cleared, no strobe until enabled.
    step(4);
    rst = 1'b1;
    enable = 1'b0;
    step();
    check("wrst_stb", int'(bus.o_note_stb), 0);
    check("wrst_gate", int'(gate), 0);
    check("wrst_phase", int'(phase), 0);
    check("wrst_instr", int'(instr), 0);
    check("wrst_playing", int'(playing), 0);
    check("wrst_tick", int'(tick), 0);
    rst = 1'b0;
    stb_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.o_note_stb) stb_cnt++;
    end
    check("wrst_no_stb", stb_cnt, 0);
    enable = 1'b1;
    step();
    check("wrst_reen_stb", int'(bus.o_note_stb), 1);
    send_note(1'b0, 60, 1, 15, 32372, 1);
    run_note(ticks, fall, eg);
    check("wrst_ticks", ticks, 2);
    check("wrst_fall", fall, 1);

    enable = 1'b0;
    step(3);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop if the run ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
